frame_shadow: RTL and testbench
===============================

FRAME_SHADOW -- requirements
Module: frame_shadow

Interface
REQ-001 Parameters (name, default, meaning):
- REG_BALL, 20, regfile index of the ball object.
- REG_LPAD, 21, left paddle index.
- REG_RPAD, 22, right paddle index.
- REG_NOTE1, 23, first of four consecutive note-register indices (23..26).
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, single system clock; all state updates on its rising edge.
- resetn, in, 1, asynchronous active-low reset.
- ctrl_writeEnable, in, 1, processor regfile write strobe.
- ctrl_writeReg, in, 5, regfile write index.
- data_writeReg, in, 32, regfile write data.
- vsync_n, in, 1, VGA vertical sync, active low, asynchronous to clock.
- ball_o, out, 32, frame-stable ball word.
- left_paddle_o, out, 32, frame-stable left paddle word.
- right_paddle_o, out, 32, frame-stable right paddle word.
- notes1_o..notes4_o, out, 32 each, frame-stable note words.
- commit_o, out, 1, one-cycle pulse marking a frame commit.
- frame_count_o, out, 16, count of commits.
- stale_o, out, 1, sticky flag: a commit occurred with no pending update.

Function
REQ-003 The block SHALL hold seven slots (ball, lpad, rpad, notes1..4), each with a 32-bit pending register, a dirty bit and a 32-bit shadow register driving its output.
REQ-004 A write is a cycle with ctrl_writeEnable=1 and ctrl_writeReg matching a slot index; the block SHALL load data_writeReg into that slot's pending register and set its dirty bit on the next edge.
REQ-005 Writes to any other index, including 0, SHALL have no effect.
REQ-006 A repeat write to a dirty slot before commit SHALL overwrite pending; last write wins.
REQ-007 vsync_n SHALL pass through a 2-flop synchronizer; a 1->0 transition of the synchronized signal SHALL raise commit_o for exactly one cycle, 3 cycles after the raw falling edge is sampled.
REQ-008 In the commit cycle, every dirty slot SHALL copy pending to shadow and clear dirty; clean slots SHALL keep their shadow value. New output values SHALL be visible the cycle after commit_o.
REQ-009 Write and commit in the same cycle: the commit SHALL use the pre-write pending value; the written value SHALL land in pending with dirty=1 and be committed at the next frame.
REQ-010 frame_count_o SHALL increment on each commit and wrap from 0xFFFF to 0x0000.
REQ-011 If a commit finds no dirty slot, stale_o SHALL set and remain set until reset.
REQ-012 Outputs SHALL never change except on the cycle following a commit, so that the VGA side never sees a partially updated object set.

Reset
REQ-013 resetn=0 SHALL asynchronously clear all of the following: pending, shadow, dirty, synchronizer flops (to 1 = idle), commit_o, frame_count_o and stale_o.
REQ-014 After reset is released, the first commit SHALL require a fresh synchronized falling edge; a vsync_n that is already low at release SHALL NOT commit.
REQ-015 Reset asserted mid-frame SHALL discard pending writes.

Structure
REQ-016 Slot count (7), slot index defaults and the 16-bit frame counter width SHALL live in the shared game constants package.
REQ-017 The synchronizer plus edge detector SHALL be one sub-module, vsync_edge_sync.

Verification
REQ-018 Write ball=0x12345678 mid-frame, then drop vsync_n. Required: ball_o=0 until commit_o, then 0x12345678; frame_count_o=1.
REQ-019 Two writes to REG_LPAD (0xA, then 0xB) in one frame, then commit. Required: left_paddle_o=0xB; all other outputs unchanged.
REQ-020 Write REG_NOTE1=0x55 in the same cycle as commit_o. Required: notes1_o unchanged at this commit, 0x55 after the next commit.
REQ-021 Commit with no writes. Required: stale_o=1 and shadows unchanged. Drive 0x10000 commits. Required: frame_count_o wraps to 0.
REQ-022 Write index 0 and index 27 with 0xFFFFFFFF, then commit. Required: all outputs 0 and stale_o=1.
REQ-023 Assert resetn low with dirty slots and vsync_n held low, then release. Required: all outputs 0 and no commit_o until the next high-to-low vsync_n transition.

Source files
------------

// File: rtl/frame_shadow_pkg.sv
// Shared game constants: slot count, default regfile indices of the
// VGA-visible objects and the frame counter width.
package frame_shadow_pkg;

  localparam int NUM_SLOTS     = 7;
  localparam int FRAME_CNT_W   = 16;

  localparam int REG_BALL_DEF  = 20;
  localparam int REG_LPAD_DEF  = 21;
  localparam int REG_RPAD_DEF  = 22;
  localparam int REG_NOTE1_DEF = 23;

  // Slot positions inside the pending/shadow arrays.
  typedef enum logic [2:0] {
    SLOT_BALL  = 3'd0,
    SLOT_LPAD  = 3'd1,
    SLOT_RPAD  = 3'd2,
    SLOT_NOTE1 = 3'd3,
    SLOT_NOTE2 = 3'd4,
    SLOT_NOTE3 = 3'd5,
    SLOT_NOTE4 = 3'd6
  } slot_e;

endpackage

// File: rtl/frame_shadow_if.sv
// Processor regfile write port as seen by the frame shadow block.
interface frame_shadow_if;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  modport master (output ctrl_writeEnable, ctrl_writeReg, data_writeReg);
  modport slave  (input  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
endinterface

// File: rtl/vsync_edge_sync.sv
// Two-flop synchronizer for the asynchronous vsync_n plus a falling-edge
// detector producing a registered one-cycle pulse.
module vsync_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic vsync_n,
  output logic fall_o
);
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic       fall_q, fall_d;
  // vld_pipe[1] marks that sync2 holds a real sample taken after reset.
  // prev only becomes 1 from a real high sample, so a vsync_n that is
  // already low at reset release cannot look like a falling edge.
  logic [1:0] vld_pipe_q, vld_pipe_d;

  // Next-state: shift the synchronizer, track previous sync value, detect 1->0
  always_comb begin
    sync1_d    = vsync_n;
    sync2_d    = sync1_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
    prev_d     = sync2_q & vld_pipe_q[1];
    fall_d     = prev_q & ~sync2_q;
  end

  // State registers; synchronizer idles high
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      vld_pipe_q <= '0;
      prev_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      vld_pipe_q <= vld_pipe_d;
      prev_q     <= prev_d;
      fall_q     <= fall_d;
    end
  end

  assign fall_o = fall_q;
endmodule

// File: rtl/frame_shadow.sv
// Double-buffers the game object registers for the VGA side: processor
// writes land in pending registers and are copied to the output shadows
// all at once on each vsync falling edge.
module frame_shadow
  import frame_shadow_pkg::*;
#(
  parameter int REG_BALL  = REG_BALL_DEF,
  parameter int REG_LPAD  = REG_LPAD_DEF,
  parameter int REG_RPAD  = REG_RPAD_DEF,
  parameter int REG_NOTE1 = REG_NOTE1_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  frame_shadow_if.slave          wbus,
  input  logic                   vsync_n,
  output logic [31:0]            ball_o,
  output logic [31:0]            left_paddle_o,
  output logic [31:0]            right_paddle_o,
  output logic [31:0]            notes1_o,
  output logic [31:0]            notes2_o,
  output logic [31:0]            notes3_o,
  output logic [31:0]            notes4_o,
  output logic                   commit_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic                   stale_o
);
  localparam logic [NUM_SLOTS-1:0][4:0] SLOT_IDX = {
    5'(REG_NOTE1 + 3), 5'(REG_NOTE1 + 2), 5'(REG_NOTE1 + 1), 5'(REG_NOTE1),
    5'(REG_RPAD), 5'(REG_LPAD), 5'(REG_BALL)
  };

  logic [NUM_SLOTS-1:0][31:0] pend_q, pend_d;
  logic [NUM_SLOTS-1:0][31:0] shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0]       dirty_q, dirty_d;
  logic [FRAME_CNT_W-1:0]     fcnt_q, fcnt_d;
  logic                       stale_q, stale_d;
  logic                       commit;

  vsync_edge_sync u_vsync (
    .clock   (clock),
    .resetn  (resetn),
    .vsync_n (vsync_n),
    .fall_o  (commit)
  );

  // Commit uses the pre-write pending values; a same-cycle write is applied
  // afterwards so it stays dirty for the following frame.
  always_comb begin
    pend_d   = pend_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    fcnt_d   = fcnt_q;
    stale_d  = stale_q;
    if (commit) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (dirty_q[i]) begin
          shadow_d[i] = pend_q[i];
          dirty_d[i]  = 1'b0;
        end
      end
      fcnt_d = fcnt_q + 1'b1;
      if (dirty_q == '0) stale_d = 1'b1;
    end
    if (wbus.ctrl_writeEnable) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wbus.ctrl_writeReg == SLOT_IDX[i]) begin
          pend_d[i]  = wbus.data_writeReg;
          dirty_d[i] = 1'b1;
        end
      end
    end
  end

  // Slot, counter and stale state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_q   <= '0;
      shadow_q <= '0;
      dirty_q  <= '0;
      fcnt_q   <= '0;
      stale_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      fcnt_q   <= fcnt_d;
      stale_q  <= stale_d;
    end
  end

  assign ball_o         = shadow_q[SLOT_BALL];
  assign left_paddle_o  = shadow_q[SLOT_LPAD];
  assign right_paddle_o = shadow_q[SLOT_RPAD];
  assign notes1_o       = shadow_q[SLOT_NOTE1];
  assign notes2_o       = shadow_q[SLOT_NOTE2];
  assign notes3_o       = shadow_q[SLOT_NOTE3];
  assign notes4_o       = shadow_q[SLOT_NOTE4];
  assign commit_o       = commit;
  assign frame_count_o  = fcnt_q;
  assign stale_o        = stale_q;
endmodule

// File: tb/tb_frame_shadow.sv
// Directed bench for frame_shadow with a frame-level reference model and
// a per-cycle compare process.
module tb_frame_shadow;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic vsync_n = 1'b1;
  logic [31:0] ball_o, left_paddle_o, right_paddle_o;
  logic [31:0] notes1_o, notes2_o, notes3_o, notes4_o;
  logic        commit_o, stale_o;
  logic [15:0] frame_count_o;

  frame_shadow_if wbus ();

  frame_shadow dut (
    .clock          (clock),
    .resetn         (resetn),
    .wbus           (wbus.slave),
    .vsync_n        (vsync_n),
    .ball_o         (ball_o),
    .left_paddle_o  (left_paddle_o),
    .right_paddle_o (right_paddle_o),
    .notes1_o       (notes1_o),
    .notes2_o       (notes2_o),
    .notes3_o       (notes3_o),
    .notes4_o       (notes4_o),
    .commit_o       (commit_o),
    .frame_count_o  (frame_count_o),
    .stale_o        (stale_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          slot_idx[7] = '{20, 21, 22, 23, 24, 25, 26};
  logic [31:0] m_pend[7];
  logic [31:0] m_shadow[7];
  bit          m_dirty[7];
  int          m_fc;
  bit          m_stale;
  bit          m_commit;
  // last four raw vsync_n samples since reset (h1 newest); n counts edges
  bit          h1, h2, h3, h4;
  int          n;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 7; i++) begin
        m_pend[i] = '0; m_shadow[i] = '0; m_dirty[i] = 0;
      end
      m_fc = 0; m_stale = 0; m_commit = 0; n = 0;
      h1 = 0; h2 = 0; h3 = 0; h4 = 0;
    end else begin
      if (m_commit) begin
        bit any;
        any = 0;
        for (int i = 0; i < 7; i++)
          if (m_dirty[i]) begin
            m_shadow[i] = m_pend[i]; m_dirty[i] = 0; any = 1;
          end
        if (!any) m_stale = 1;
        m_fc = (m_fc + 1) % 65536;
      end
      if (wbus.ctrl_writeEnable)
        for (int i = 0; i < 7; i++)
          if (int'(wbus.ctrl_writeReg) == slot_idx[i]) begin
            m_pend[i] = wbus.data_writeReg; m_dirty[i] = 1;
          end
      h4 = h3; h3 = h2; h2 = h1; h1 = vsync_n; n++;
      // a raw high sample followed by a low sample pulses commit two edges
      // after the low sample was taken
      m_commit = (n >= 4) && !h3 && h4;
    end
  end

  logic [31:0] dut_out[7];
  assign dut_out[0] = ball_o;
  assign dut_out[1] = left_paddle_o;
  assign dut_out[2] = right_paddle_o;
  assign dut_out[3] = notes1_o;
  assign dut_out[4] = notes2_o;
  assign dut_out[5] = notes3_o;
  assign dut_out[6] = notes4_o;

  // per-cycle comparison away from the active edge
  always @(negedge clock) begin
    if (resetn) begin
      for (int i = 0; i < 7; i++) check($sformatf("slot%0d", i), dut_out[i], m_shadow[i]);
      check("commit_o", {31'd0, commit_o}, {31'd0, m_commit});
      check("frame_count_o", {16'd0, frame_count_o}, 32'(m_fc));
      check("stale_o", {31'd0, stale_o}, {31'd0, m_stale});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    wbus.ctrl_writeEnable = 1'b1;
    wbus.ctrl_writeReg    = 5'(idx);
    wbus.data_writeReg    = data;
    tick();
    wbus.ctrl_writeEnable = 1'b0;
  endtask

  // drop vsync long enough to commit, then re-arm the detector
  task automatic commit_frame();
    vsync_n = 1'b0;
    repeat (4) tick();
    vsync_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    wbus.ctrl_writeEnable = 1'b0;
    wbus.ctrl_writeReg    = '0;
    wbus.data_writeReg    = '0;
    #23 resetn = 1'b1;
    repeat (3) tick();
    check("rst ball", ball_o, 32'h0);
    check("rst fc", {16'd0, frame_count_o}, 32'h0);
    check("rst stale", {31'd0, stale_o}, 32'h0);

    // ball written mid-frame appears only after commit
    wr(20, 32'h12345678);
    check("ball pre", ball_o, 32'h0);
    vsync_n = 1'b0;
    repeat (3) tick();
    check("commit lat", {31'd0, commit_o}, 32'h1);
    check("ball at commit", ball_o, 32'h0);
    tick();
    check("ball post", ball_o, 32'h12345678);
    check("fc 1", {16'd0, frame_count_o}, 32'h1);
    vsync_n = 1'b1;
    repeat (3) tick();

    // last write wins
    wr(21, 32'hA);
    wr(21, 32'hB);
    commit_frame();
    check("lpad B", left_paddle_o, 32'hB);
    check("ball kept", ball_o, 32'h12345678);

    // write coincident with commit is deferred one frame
    wr(22, 32'h77);
    vsync_n = 1'b0;
    repeat (3) tick();
    check("commit for note", {31'd0, commit_o}, 32'h1);
    wbus.ctrl_writeEnable = 1'b1;
    wbus.ctrl_writeReg    = 5'd23;
    wbus.data_writeReg    = 32'h55;
    tick();
    wbus.ctrl_writeEnable = 1'b0;
    check("note1 deferred", notes1_o, 32'h0);
    check("rpad", right_paddle_o, 32'h77);
    vsync_n = 1'b1;
    repeat (2) tick();
    commit_frame();
    check("note1 landed", notes1_o, 32'h55);
    check("not stale", {31'd0, stale_o}, 32'h0);

    // empty commit
    commit_frame();
    check("stale set", {31'd0, stale_o}, 32'h1);
    check("note1 held", notes1_o, 32'h55);
    check("fc 5", {16'd0, frame_count_o}, 32'h5);

    // non-slot indices are ignored
    resetn = 1'b0; #2 resetn = 1'b1;
    wr(0, 32'hFFFFFFFF);
    wr(27, 32'hFFFFFFFF);
    commit_frame();
    check("idx0/27 ball", ball_o, 32'h0);
    check("idx0/27 note4", notes4_o, 32'h0);
    check("idx0/27 stale", {31'd0, stale_o}, 32'h1);

    // reset with dirty slots and vsync held low
    resetn = 1'b0; #2 resetn = 1'b1;
    wr(20, 32'hDEAD);
    commit_frame();
    check("ball dead", ball_o, 32'hDEAD);
    wr(21, 32'hBEEF);
    vsync_n = 1'b0;
    tick();
    resetn = 1'b0;
    #2;
    check("async clr ball", ball_o, 32'h0);
    #2 resetn = 1'b1;
    repeat (6) tick();
    check("no commit low", {16'd0, frame_count_o}, 32'h0);
    vsync_n = 1'b1;
    repeat (3) tick();
    vsync_n = 1'b0;
    repeat (3) tick();
    check("fresh edge commit", {31'd0, commit_o}, 32'h1);
    tick();
    check("lpad discarded", left_paddle_o, 32'h0);
    check("fc after rst", {16'd0, frame_count_o}, 32'h1);
    vsync_n = 1'b1;
    repeat (2) tick();

    // counter wrap: 65535 more commits bring 1 back round to 0
    for (int i = 0; i < 65535; i++) begin
      vsync_n = 1'b0;
      tick();
      vsync_n = 1'b1;
      tick();
    end
    repeat (5) tick();
    check("fc wrap", {16'd0, frame_count_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
